// File: rtl/axi_interface_pkg.sv
// Shared AXI-Lite types for the peripheral-side channel responders:
// bus sizes, response codes and the write-path FSM encoding.
package axi_interface_pkg;

  localparam int AXI_ADDR_SIZE = 32;
  localparam int AXI_DATA_SIZE = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_response_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ADDR = 3'd1,
    WAIT_DATA = 3'd2,
    WRITE     = 3'd3,
    RESPOND   = 3'd4
  } axi_write_state_t;

  // Inclusive unsigned range check used by the address decoder.
  function automatic logic addr_in_range(
    input logic [AXI_ADDR_SIZE-1:0] addr,
    input logic [AXI_ADDR_SIZE-1:0] low,
    input logic [AXI_ADDR_SIZE-1:0] high
  );
    return (addr >= low) && (addr <= high);
  endfunction

endpackage

// File: rtl/axi_write_interface.sv
// AW/W/B channel bundle; the write-side responder sits on the slave modport.
interface axi_write_interface
  import axi_interface_pkg::*;
();

  logic [AXI_ADDR_SIZE-1:0]   AWADDR;
  logic                       AWVALID;
  logic                       AWREADY;
  logic [AXI_DATA_SIZE*8-1:0] WDATA;
  logic [AXI_DATA_SIZE-1:0]   WSTRB;
  logic                       WVALID;
  logic                       WREADY;
  axi_response_t              BRESP;
  logic                       BVALID;
  logic                       BREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi_write_slave_controller.sv
// AXI-Lite write responder: accepts AW and W in any order, decodes the address
// window, issues one local register write and reports its status on B.
module axi_write_slave_controller
  import axi_interface_pkg::*;
#(
  parameter logic [AXI_ADDR_SIZE-1:0] ADDR_LOW  = '0,
  parameter logic [AXI_ADDR_SIZE-1:0] ADDR_HIGH = 32'hFFF
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AXI_ADDR_SIZE-1:0]   AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [AXI_DATA_SIZE*8-1:0] WDATA,
  input  logic [AXI_DATA_SIZE-1:0]   WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output axi_response_t              BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [AXI_ADDR_SIZE-1:0]   write_address_o,
  output logic [AXI_DATA_SIZE*8-1:0] write_data_o,
  output logic [AXI_DATA_SIZE-1:0]   write_strobe_o,
  output logic                       write_request_o,
  input  logic                       write_done_i,
  input  logic                       write_error_i,
  output axi_write_state_t           state_o
);

  // Handshakes: a beat transfers on a rising ACLK edge where VALID and READY
  // are both 1. READY/BVALID are registered and never look at the opposite
  // side combinationally; a master holds VALID and payload until it transfers.

  axi_write_state_t state_q, state_d;

  logic [AXI_ADDR_SIZE-1:0]   addr_hold_q;
  logic [AXI_DATA_SIZE*8-1:0] data_hold_q;
  logic [AXI_DATA_SIZE-1:0]   strb_hold_q;

  logic                       awready_q, awready_d;
  logic                       wready_q, wready_d;
  logic                       bvalid_q, bvalid_d;
  axi_response_t              bresp_q, bresp_d;
  logic                       request_q, request_d;
  logic [AXI_ADDR_SIZE-1:0]   local_addr_q, local_addr_d;
  logic [AXI_DATA_SIZE*8-1:0] local_data_q, local_data_d;
  logic [AXI_DATA_SIZE-1:0]   local_strb_q, local_strb_d;

  logic                       aw_hs;
  logic                       w_hs;
  logic                       launch;
  logic                       addr_ok;
  logic [AXI_ADDR_SIZE-1:0]   addr_eff;
  logic [AXI_DATA_SIZE*8-1:0] data_eff;
  logic [AXI_DATA_SIZE-1:0]   strb_eff;

  assign aw_hs = AWVALID & awready_q;
  assign w_hs  = WVALID & wready_q;

  // Whichever half arrived earlier comes from its holding register.
  assign addr_eff = (state_q == WAIT_DATA) ? addr_hold_q : AWADDR;
  assign data_eff = (state_q == WAIT_ADDR) ? data_hold_q : WDATA;
  assign strb_eff = (state_q == WAIT_ADDR) ? strb_hold_q : WSTRB;
  assign addr_ok  = addr_in_range(addr_eff, ADDR_LOW, ADDR_HIGH);

  assign launch = ((state_q == IDLE)      && aw_hs && w_hs) ||
                  ((state_q == WAIT_ADDR) && aw_hs)         ||
                  ((state_q == WAIT_DATA) && w_hs);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bresp_d = bresp_q;
    unique case (state_q)
      IDLE: begin
        if (aw_hs && !w_hs) begin
          state_d = WAIT_DATA;
        end else if (w_hs && !aw_hs) begin
          state_d = WAIT_ADDR;
        end
      end
      WAIT_ADDR, WAIT_DATA: ;
      WRITE: begin
        if (write_done_i) begin
          state_d = RESPOND;
          bresp_d = write_error_i ? SLVERR : OKAY;
        end
      end
      RESPOND: begin
        if (BREADY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Out-of-window writes never reach the peripheral.
    if (launch) begin
      if (addr_ok) begin
        state_d = WRITE;
      end else begin
        state_d = RESPOND;
        bresp_d = DECERR;
      end
    end
  end

  always_comb begin
    awready_d    = (state_d == IDLE) || (state_d == WAIT_ADDR);
    wready_d     = (state_d == IDLE) || (state_d == WAIT_DATA);
    bvalid_d     = (state_d == RESPOND);
    request_d    = (state_d == WRITE) && (state_q != WRITE);
    local_addr_d = local_addr_q;
    local_data_d = local_data_q;
    local_strb_d = local_strb_q;
    if (request_d) begin
      local_addr_d = addr_eff - ADDR_LOW;
      local_data_d = data_eff;
      local_strb_d = strb_eff;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_hold_q  <= '0;
      data_hold_q  <= '0;
      strb_hold_q  <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= OKAY;
      request_q    <= 1'b0;
      local_addr_q <= '0;
      local_data_q <= '0;
      local_strb_q <= '0;
    end else begin
      if (aw_hs) begin
        addr_hold_q <= AWADDR;
      end
      if (w_hs) begin
        data_hold_q <= WDATA;
        strb_hold_q <= WSTRB;
      end
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      request_q    <= request_d;
      local_addr_q <= local_addr_d;
      local_data_q <= local_data_d;
      local_strb_q <= local_strb_d;
    end
  end

  assign AWREADY         = awready_q;
  assign WREADY          = wready_q;
  assign BVALID          = bvalid_q;
  assign BRESP           = bresp_q;
  assign write_request_o = request_q;
  assign write_address_o = local_addr_q;
  assign write_data_o    = local_data_q;
  assign write_strobe_o  = local_strb_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_axi_write_slave_controller.sv
// Bench for axi_write_slave_controller: directed scenarios plus randomized
// writes checked against a window/latency reference model.
module tb_axi_write_slave_controller;
  import axi_interface_pkg::*;

  localparam int AW = AXI_ADDR_SIZE;
  localparam int DW = AXI_DATA_SIZE * 8;
  localparam int SW = AXI_DATA_SIZE;
  localparam logic [AW-1:0] LOW  = 32'h0000_1000;
  localparam logic [AW-1:0] HIGH = 32'h0000_1FFF;

  logic            ACLK;
  logic            ARESET;
  logic [AW-1:0]   AWADDR;
  logic            AWVALID;
  logic            AWREADY;
  logic [DW-1:0]   WDATA;
  logic [SW-1:0]   WSTRB;
  logic            WVALID;
  logic            WREADY;
  axi_response_t   BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [AW-1:0]   write_address_o;
  logic [DW-1:0]   write_data_o;
  logic [SW-1:0]   write_strobe_o;
  logic            write_request_o;
  logic            write_done_i;
  logic            write_error_i;
  axi_write_state_t dbg_state;

  axi_write_slave_controller #(.ADDR_LOW(LOW), .ADDR_HIGH(HIGH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .write_address_o(write_address_o), .write_data_o(write_data_o),
    .write_strobe_o(write_strobe_o), .write_request_o(write_request_o),
    .write_done_i(write_done_i), .write_error_i(write_error_i),
    .state_o(dbg_state)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int tests_run;
  int tests_failed;
  logic [1:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  // Observations of the last transaction run by run_txn.
  int            obs_req_cnt, obs_req_lat, obs_bv_lat;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;
  logic [SW-1:0] obs_strb;
  logic [1:0]    obs_bresp;
  bit            obs_bresp_stable, obs_local_stable, obs_wait_ok, obs_wait_seen;
  bit            obs_ready_after, obs_timeout;

  // Reference model: response code from the address window and peripheral status.
  function automatic logic [1:0] model_resp(input logic [AW-1:0] a, input bit err);
    if (a < LOW || a > HIGH) return 2'b11;
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic bit model_hit(input logic [AW-1:0] a);
    return (a >= LOW) && (a <= HIGH);
  endfunction

  // Inputs change and handshakes are judged at negedges; outputs are sampled there too.
  task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                         input int done_dly, input bit err, input int bready_dly);
    bit aw_acc, w_acc, done_sent, resp_hs;
    int hs_n, req_n, bv_n;
    aw_acc = 0; w_acc = 0; done_sent = 0; resp_hs = 0;
    hs_n = -1; req_n = -1; bv_n = -1;
    obs_req_cnt = 0; obs_bresp_stable = 1; obs_local_stable = 1;
    obs_wait_ok = 1; obs_wait_seen = 0; obs_ready_after = 0; obs_timeout = 0;
    obs_addr = '0; obs_data = '0; obs_strb = '0; obs_bresp = 2'bxx;
    for (int n = 0; n < 200; n++) begin
      @(negedge ACLK);
      if (write_request_o) begin
        obs_req_cnt++;
        req_n = n;
        obs_addr = write_address_o; obs_data = write_data_o; obs_strb = write_strobe_o;
      end else if (req_n >= 0 && bv_n < 0) begin
        if (write_address_o !== obs_addr || write_data_o !== obs_data ||
            write_strobe_o !== obs_strb) obs_local_stable = 0;
      end
      if (BVALID) begin
        if (bv_n < 0) begin
          bv_n = n;
          obs_bresp = BRESP;
        end else if (BRESP !== obs_bresp) begin
          obs_bresp_stable = 0;
        end
      end
      if (aw_acc ^ w_acc) begin
        obs_wait_seen = 1;
        if (AWREADY !== !aw_acc || WREADY !== !w_acc) obs_wait_ok = 0;
      end
      if (resp_hs) begin
        obs_ready_after = AWREADY && WREADY && !BVALID;
        break;
      end
      AWVALID = !aw_acc && (n >= aw_dly);
      AWADDR  = AWVALID ? addr : AW'($urandom);
      WVALID  = !w_acc && (n >= w_dly);
      WDATA   = WVALID ? data : DW'($urandom);
      WSTRB   = WVALID ? strb : SW'($urandom);
      if (AWVALID && AWREADY) begin aw_acc = 1; hs_n = n; end
      if (WVALID && WREADY) begin w_acc = 1; hs_n = n; end
      write_done_i  = (req_n >= 0) && !done_sent && (n >= req_n + done_dly);
      write_error_i = write_done_i && err;
      if (write_done_i) done_sent = 1;
      BREADY  = (bv_n >= 0) && (n >= bv_n + bready_dly);
      resp_hs = BREADY && BVALID;
    end
    if (!resp_hs) obs_timeout = 1;
    obs_req_lat = (req_n >= 0) ? req_n - hs_n : -1;
    obs_bv_lat  = (bv_n >= 0) ? bv_n - hs_n : -1;
    AWVALID = 0; WVALID = 0; BREADY = 0; write_done_i = 0; write_error_i = 0;
  endtask

  task automatic test_reset();
    ARESET = 1;
    repeat (3) @(negedge ACLK);
    tests_run++;
    if ({AWREADY, WREADY, BVALID, write_request_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {AWREADY, WREADY, BVALID, write_request_o});
    end
    tests_run++;
    if (BRESP !== OKAY || write_address_o !== '0 || write_data_o !== '0 || write_strobe_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_payload: bresp %0h addr %0h data %0h strb %0h expected all 0",
               BRESP, write_address_o, write_data_o, write_strobe_o);
    end
    ARESET = 0;
    #1;
    tests_run++;
    if (AWREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_early: AWREADY %b expected 0", AWREADY);
    end
    @(negedge ACLK);
    tests_run++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b%b expected 11", AWREADY, WREADY);
    end
  endtask

  task automatic test_same_cycle();
    exp_q.push_back(model_resp(LOW + 32'h10, 0));
    run_txn(LOW + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0);
    tests_run++;
    if (obs_timeout || obs_req_cnt != 1 || obs_req_lat != 1) begin
      tests_failed++;
      $display("FAIL same_req: timeout %0d count %0d lat %0d expected 0 1 1", obs_timeout, obs_req_cnt, obs_req_lat);
    end
    tests_run++;
    if (obs_addr !== 32'h10 || obs_data !== 32'hDEAD_BEEF || obs_strb !== 4'hF) begin
      tests_failed++;
      $display("FAIL same_payload: got %0h %0h %0h expected 10 deadbeef f", obs_addr, obs_data, obs_strb);
    end
    tests_run++;
    if (obs_bv_lat != 2 || obs_bresp !== exp_q.pop_front() || !obs_ready_after) begin
      tests_failed++;
      $display("FAIL same_resp: bvalid lat %0d bresp %0h ready_after %0d expected 2 0 1", obs_bv_lat, obs_bresp, obs_ready_after);
    end
  endtask

  task automatic test_w_first();
    exp_q.push_back(model_resp(LOW + 32'h20, 0));
    run_txn(LOW + 32'h20, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0);
    tests_run++;
    if (!obs_wait_seen || !obs_wait_ok) begin
      tests_failed++;
      $display("FAIL wfirst_ready: seen %0d ok %0d expected AWREADY=1 WREADY=0 while waiting", obs_wait_seen, obs_wait_ok);
    end
    tests_run++;
    if (obs_req_cnt != 1 || obs_req_lat != 1 || obs_addr !== 32'h20 ||
        obs_data !== 32'h1234_5678 || obs_strb !== 4'h3) begin
      tests_failed++;
      $display("FAIL wfirst_payload: cnt %0d lat %0d %0h %0h %0h expected 1 1 20 12345678 3",
               obs_req_cnt, obs_req_lat, obs_addr, obs_data, obs_strb);
    end
    tests_run++;
    if (obs_timeout || obs_bresp !== exp_q.pop_front() || obs_bv_lat != 2) begin
      tests_failed++;
      $display("FAIL wfirst_resp: timeout %0d bresp %0h lat %0d expected 0 0 2", obs_timeout, obs_bresp, obs_bv_lat);
    end
  endtask

  task automatic test_decode();
    logic [AW-1:0] addrs[4];
    addrs[0] = HIGH + 4; addrs[1] = LOW - 4; addrs[2] = LOW; addrs[3] = HIGH;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_resp(addrs[i], 0));
      run_txn(addrs[i], 32'hA5A5_0000 + i, 4'hF, i % 2, (i + 1) % 2, 0, 0, 1);
      tests_run++;
      if (obs_timeout || obs_bresp !== exp_q.pop_front()) begin
        tests_failed++;
        $display("FAIL decode_resp[%0d]: addr %0h bresp %0h timeout %0d", i, addrs[i], obs_bresp, obs_timeout);
      end
      tests_run++;
      if (model_hit(addrs[i]) ? (obs_req_cnt != 1 || obs_addr !== addrs[i] - LOW || obs_bv_lat != 2)
                              : (obs_req_cnt != 0 || obs_bv_lat != 1)) begin
        tests_failed++;
        $display("FAIL decode_path[%0d]: req %0d local %0h bvalid lat %0d", i, obs_req_cnt, obs_addr, obs_bv_lat);
      end
    end
  endtask

  task automatic test_slverr_backpressure();
    exp_q.push_back(model_resp(LOW + 32'h44, 1));
    run_txn(LOW + 32'h44, 32'h0BAD_F00D, 4'hC, 0, 1, 5, 1, 4);
    tests_run++;
    if (obs_bresp !== exp_q.pop_front() || !obs_bresp_stable || obs_bv_lat != 7) begin
      tests_failed++;
      $display("FAIL slverr_resp: bresp %0h stable %0d lat %0d expected 2 1 7", obs_bresp, obs_bresp_stable, obs_bv_lat);
    end
    tests_run++;
    if (!obs_local_stable || obs_req_cnt != 1 || obs_timeout || !obs_ready_after) begin
      tests_failed++;
      $display("FAIL slverr_hold: local_stable %0d req %0d timeout %0d ready_after %0d",
               obs_local_stable, obs_req_cnt, obs_timeout, obs_ready_after);
    end
  endtask

  task automatic test_zero_strobe();
    exp_q.push_back(model_resp(LOW + 32'h80, 0));
    run_txn(LOW + 32'h80, 32'hFFFF_FFFF, 4'h0, 2, 0, 1, 0, 0);
    tests_run++;
    if (obs_req_cnt != 1 || obs_strb !== 4'h0 || obs_addr !== 32'h80 || obs_bresp !== exp_q.pop_front()) begin
      tests_failed++;
      $display("FAIL zero_strobe: req %0d strb %0h addr %0h bresp %0h expected 1 0 80 0",
               obs_req_cnt, obs_strb, obs_addr, obs_bresp);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int region, ad, wd, dd, bd;
    bit e;
    for (int i = 0; i < 24; i++) begin
      region = $urandom_range(0, 3);
      if (region == 0)      a = LOW - 4 * $urandom_range(1, 16);
      else if (region == 1) a = HIGH + 1 + 4 * $urandom_range(0, 16);
      else                  a = LOW + 4 * $urandom_range(0, 1023);
      d = $urandom; s = SW'($urandom);
      ad = $urandom_range(0, 3); wd = $urandom_range(0, 3);
      dd = $urandom_range(0, 4); bd = $urandom_range(0, 3);
      e = 1'($urandom_range(0, 1));
      exp_q.push_back(model_resp(a, e));
      exp_addr_q.push_back(a - LOW);
      run_txn(a, d, s, ad, wd, dd, e, bd);
      tests_run++;
      if (obs_timeout || obs_bresp !== exp_q.pop_front() || !obs_bresp_stable || !obs_ready_after) begin
        tests_failed++;
        $display("FAIL rand_resp[%0d]: addr %0h bresp %0h stable %0d timeout %0d ready_after %0d",
                 i, a, obs_bresp, obs_bresp_stable, obs_timeout, obs_ready_after);
      end
      tests_run++;
      if (model_hit(a)) begin
        if (obs_req_cnt != 1 || obs_req_lat != 1 || obs_addr !== exp_addr_q.pop_front() ||
            obs_data !== d || obs_strb !== s || obs_bv_lat != 2 + dd || !obs_local_stable) begin
          tests_failed++;
          $display("FAIL rand_write[%0d]: req %0d lat %0d local %0h %0h %0h blat %0d expected 1 1 %0h %0h %0h %0d",
                   i, obs_req_cnt, obs_req_lat, obs_addr, obs_data, obs_strb, obs_bv_lat, a - LOW, d, s, 2 + dd);
        end
      end else begin
        void'(exp_addr_q.pop_front());
        if (obs_req_cnt != 0 || obs_bv_lat != 1) begin
          tests_failed++;
          $display("FAIL rand_miss[%0d]: req %0d bvalid lat %0d expected 0 1", i, obs_req_cnt, obs_bv_lat);
        end
      end
      tests_run++;
      if (obs_wait_seen && !obs_wait_ok) begin
        tests_failed++;
        $display("FAIL rand_wait[%0d]: ready pattern wrong while one channel held", i);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int bv_seen;
    bit req_seen;
    req_seen = 0;
    bv_seen = 0;
    @(negedge ACLK);
    AWADDR = LOW + 32'h30; WDATA = 32'hCAFE_0001; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    req_seen = write_request_o;
    tests_run++;
    if (!req_seen) begin
      tests_failed++;
      $display("FAIL midreset_req: write_request_o %b expected 1", write_request_o);
    end
    #2 ARESET = 1;
    #1;
    tests_run++;
    if ({AWREADY, WREADY, BVALID, write_request_o} !== 4'b0000 || BRESP !== OKAY ||
        write_address_o !== '0 || write_data_o !== '0 || write_strobe_o !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: flags %b bresp %0h addr %0h data %0h strb %0h expected 0",
               {AWREADY, WREADY, BVALID, write_request_o}, BRESP, write_address_o, write_data_o, write_strobe_o);
    end
    @(negedge ACLK);
    ARESET = 0;
    #1;
    tests_run++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_early: ready %b%b expected 00", AWREADY, WREADY);
    end
    @(negedge ACLK);
    tests_run++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ready: ready %b%b expected 11", AWREADY, WREADY);
    end
    write_done_i = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      write_done_i = 0;
      if (BVALID || write_request_o) bv_seen++;
    end
    tests_run++;
    if (bv_seen != 0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: %0d cycles with BVALID/request, expected 0", bv_seen);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    ARESET = 1; AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0;
    BREADY = 0; write_done_i = 0; write_error_i = 0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_decode();
    test_slverr_backpressure();
    test_zero_strobe();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_write_slave_controller.md
# axi_write_slave_controller

AXI-Lite write-side responder that terminates the AW, W and B channels for one peripheral and converts each accepted write into a single-beat local register-write request. It is the write-direction counterpart of the read-channel interface. It sits between the interconnect and a peripheral's register file. It accepts address and data in either order, decodes the address range, and returns the peripheral's completion status on B.

## Interface
Parameters:
- ADDR_LOW, 0: lowest byte address owned by this peripheral (inclusive).
- ADDR_HIGH, 32'hFFF: highest byte address owned (inclusive).

Ports:
- ACLK, input, 1: system clock; all logic on rising edge.
- ARESET, input, 1: asynchronous, active-high reset.
- AWADDR, input, AXI_ADDR_SIZE: write address.
- AWVALID, input, 1: write address valid.
- AWREADY, output, 1: address accepted.
- WDATA, input, AXI_DATA_SIZE x 8: write data, byte-organised.
- WSTRB, input, AXI_DATA_SIZE: byte enables.
- WVALID, input, 1: write data valid.
- WREADY, output, 1: data accepted.
- BRESP, output, axi_response_t: write response.
- BVALID, output, 1: response valid.
- BREADY, input, 1: master accepts response.
- write_address_o, output, AXI_ADDR_SIZE: local write address (AWADDR − ADDR_LOW).
- write_data_o, output, AXI_DATA_SIZE x 8: local write data.
- write_strobe_o, output, AXI_DATA_SIZE: local byte enables.
- write_request_o, output, 1: single-cycle local write strobe.
- write_done_i, input, 1: peripheral completed the write.
- write_error_i, input, 1: peripheral error; sampled with write_done_i.

## Operation
- FSM states: IDLE, WAIT_ADDR (data held), WAIT_DATA (address held), WRITE, RESPOND.
- AWREADY = 1 in IDLE and WAIT_ADDR; WREADY = 1 in IDLE and WAIT_DATA; both 0 elsewhere. Only one outstanding write.
- IDLE:
  - AW and W handshakes in the same cycle go to WRITE.
  - AW handshake only goes to WAIT_DATA.
  - W handshake only goes to WAIT_ADDR.
- WAIT_ADDR / WAIT_DATA: the missing handshake goes to WRITE.
- Address and data/strobe are captured into holding registers on their handshake.
- Decode: an address outside [ADDR_LOW, ADDR_HIGH] skips WRITE and goes directly to RESPOND with DECERR. No local request is issued.
- WRITE:
  - write_request_o is 1 for exactly the first cycle in WRITE.
  - Local address, data and strobe outputs are stable for the whole state.
  - write_done_i is honoured in any WRITE cycle, including the request cycle.
  - On write_done_i, go to RESPOND with BRESP = SLVERR if write_error_i, else OKAY.
- RESPOND: BVALID = 1 and BRESP is held stable until BREADY; on BVALID & BREADY go to IDLE.
- WSTRB = 0 is still forwarded as a request; the peripheral ignores all bytes and the response is OKAY.
- Address arithmetic is unsigned, width AXI_ADDR_SIZE, with both bounds inclusive. The subtraction never wraps because it is applied only to in-range addresses.

## Timing
- Reset values:
  - AWREADY, WREADY, BVALID, write_request_o = 0.
  - BRESP = OKAY.
  - write_address_o, write_data_o, write_strobe_o = 0.
  - State = IDLE.
- AWREADY and WREADY first rise on the first ACLK edge after ARESET deasserts.
- All outputs are registered.
- Latency, with the handshake at edge T:
  - write_request_o is high in cycle T+1.
  - If write_done_i arrives at T+1, BVALID is high from T+2.
  - If BREADY is already high, AWREADY/WREADY reassert at T+3.
- Decode-miss latency: BVALID is high from T+1.
- Split AW/W: the latency above is counted from the later of the two handshakes.
- BVALID never depends combinationally on BREADY.
- ARESET mid-transaction: immediate return to IDLE. Held address, data and the pending response are discarded and write_request_o drops. The master must also be reset.
- AWVALID/WVALID asserted while the corresponding READY is 0 is not accepted and causes no state change.

## Structure
- axi_interface_pkg holds:
  - AXI_ADDR_SIZE and AXI_DATA_SIZE.
  - axi_response_t with OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11.
  - A new axi_write_state_t enum for the FSM.
- A companion axi_write_interface (master/slave modports for AW/W/B) is added alongside the read interface. This block binds to its slave modport.
- No sub-module: the FSM and holding registers stay in one module.

## Test plan
- AWADDR=0x10 and WDATA=0xDEADBEEF with WSTRB=4'hF in the same cycle; write_done_i at T+1 -> write_request_o for one cycle with write_address_o=0x10, then BVALID with BRESP=OKAY at T+2.
- W first (0x12345678, WSTRB=4'h3), AW (0x20) three cycles later -> AWREADY=1/WREADY=0 while waiting; request carries both held values; BRESP=OKAY.
- AWADDR=ADDR_HIGH+4 -> no write_request_o; BVALID with DECERR one cycle after the handshake.
- write_done_i=1 with write_error_i=1 after 5 cycles; BREADY held 0 for 4 cycles -> BVALID/BRESP=SLVERR stable throughout; IDLE only after BREADY.
- ARESET asserted during WRITE -> all outputs return to reset values immediately; AWREADY/WREADY reassert one edge after release; no BVALID is produced.
